// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: funct codes, the
// sequencer state encoding and the funct classification helpers.
package alu_ctrl_pkg;

    localparam logic [5:0] FN_AND    = 6'd36;
    localparam logic [5:0] FN_OR     = 6'd37;
    localparam logic [5:0] FN_ADD    = 6'd32;
    localparam logic [5:0] FN_SUB    = 6'd34;
    localparam logic [5:0] FN_SLT    = 6'd42;
    localparam logic [5:0] FN_SLL    = 6'd0;
    localparam logic [5:0] FN_MULTU  = 6'd25;
    localparam logic [5:0] FN_DIVU   = 6'd27;
    localparam logic [5:0] HILO_OPEN = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        HILO = 2'd2
    } state_t;

    // True for the ops that need the WIDTH-cycle iteration sequence.
    function automatic logic is_multicycle(input logic [5:0] f);
        return (f == FN_MULTU) || (f == FN_DIVU);
    endfunction

    // True for every funct code the sequencer knows how to steer.
    function automatic logic is_supported(input logic [5:0] f);
        return (f == FN_AND) || (f == FN_OR) || (f == FN_ADD) ||
               (f == FN_SUB) || (f == FN_SLT) || (f == FN_SLL) ||
               is_multicycle(f);
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for multi-cycle ops. Counts up from zero while enabled,
// saturates at WIDTH-1 so it can never wrap inside an op, and flags the
// final iteration. Kept generic so the divider can reuse it.
module iter_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Clear has priority; otherwise advance only until the last iteration.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: accepts a funct code through start/busy/done,
// drives the unit select buses, and sequences MULTU/DIVU through WIDTH
// iteration cycles followed by a single HiLo write cycle.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    output logic [5:0]       alu_sel,
    output logic [5:0]       sht_sel,
    output logic [5:0]       mul_sel,
    output logic [5:0]       mux_sel,
    output logic             busy,
    output logic             done,
    output logic             hilo_we,
    output logic             illegal,
    output logic [CNT_W-1:0] iter
);

    state_t     state;
    logic [5:0] sel_q;
    logic [5:0] fn_q;
    logic       accept;
    logic       cnt_clear;
    logic       cnt_en;
    logic       cnt_term;

    assign accept = (state == IDLE) && start;

    // Counter restarts on reset, on a new multi-cycle accept and when leaving HILO.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        if (rst || (state == HILO) || (accept && is_multicycle(funct))) begin
            cnt_clear = 1'b1;
        end
        if (state == ITER) begin
            cnt_en = 1'b1;
        end
    end

    iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk      (clk),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .count    (iter),
        .terminal (cnt_term)
    );

    // Sequencer FSM with all control outputs registered; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_q   <= FN_ADD;
            fn_q    <= FN_ADD;
            busy    <= 1'b0;
            done    <= 1'b0;
            hilo_we <= 1'b0;
            illegal <= 1'b0;
        end else begin
            done    <= 1'b0;
            hilo_we <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!is_supported(funct)) begin
                            illegal <= 1'b1;
                        end else if (is_multicycle(funct)) begin
                            sel_q <= funct;
                            fn_q  <= funct;
                            busy  <= 1'b1;
                            state <= ITER;
                        end else begin
                            sel_q <= funct;
                            fn_q  <= funct;
                            done  <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    if (cnt_term) begin
                        state   <= HILO;
                        sel_q   <= HILO_OPEN;
                        hilo_we <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                HILO: begin
                    state <= IDLE;
                    sel_q <= fn_q;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign alu_sel = sel_q;
    assign sht_sel = sel_q;
    assign mul_sel = sel_q;
    assign mux_sel = sel_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: one WIDTH=32 instance for the
// single-cycle, MULTU, illegal and reset-abort cases, and one WIDTH=8
// instance for DIVU with an ignored start while busy.
module tb_alu_control_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] funct;
    logic       start8;
    logic [5:0] funct8;

    logic [5:0] alu_sel, sht_sel, mul_sel, mux_sel;
    logic       busy, done, hilo_we, illegal;
    logic [5:0] iter;

    logic [5:0] alu_sel8, sht_sel8, mul_sel8, mux_sel8;
    logic       busy8, done8, hilo_we8, illegal8;
    logic [3:0] iter8;

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    alu_control_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct   (funct),
        .alu_sel (alu_sel),
        .sht_sel (sht_sel),
        .mul_sel (mul_sel),
        .mux_sel (mux_sel),
        .busy    (busy),
        .done    (done),
        .hilo_we (hilo_we),
        .illegal (illegal),
        .iter    (iter)
    );

    alu_control_seq #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .start   (start8),
        .funct   (funct8),
        .alu_sel (alu_sel8),
        .sht_sel (sht_sel8),
        .mul_sel (mul_sel8),
        .mux_sel (mux_sel8),
        .busy    (busy8),
        .done    (done8),
        .hilo_we (hilo_we8),
        .illegal (illegal8),
        .iter    (iter8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [5:0] f);
        start = s;
        funct = f;
    endtask

    logic [5:0] single_fns [6] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0};
    int         done_count;
    int         busy_seen;
    int         pulse_seen;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        funct  = 6'd0;
        start8 = 1'b0;
        funct8 = 6'd0;

        // Reset held for two cycles
        tick();
        tick();
        checkOutput("rst_alu_sel", alu_sel, 6'h20);
        checkOutput("rst_sht_sel", sht_sel, 6'h20);
        checkOutput("rst_mul_sel", mul_sel, 6'h20);
        checkOutput("rst_mux_sel", mux_sel, 6'h20);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_hilo_we", hilo_we, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_iter", iter, 0);
        rst = 1'b0;
        tick();
        checkOutput("idle_done", done, 0);

        // Back-to-back single-cycle ops
        done_count = 0;
        busy_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, single_fns[i]);
            tick();
            checkOutput($sformatf("single_sel_%0d", i), alu_sel, single_fns[i]);
            checkOutput($sformatf("single_mux_%0d", i), mux_sel, single_fns[i]);
            if (done) done_count++;
            if (busy) busy_seen++;
        end
        applyStimulus(1'b0, 6'd0);
        tick();
        if (done) done_count++;
        if (busy) busy_seen++;
        checkOutput("single_done_count", done_count, 6);
        checkOutput("single_busy_seen", busy_seen, 0);

        // MULTU with WIDTH=32
        applyStimulus(1'b1, 6'd25);
        tick();
        applyStimulus(1'b0, 6'd0);
        pulse_seen = 0;
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("multu_iter_%0d", k), iter, k);
            if (!busy || done || hilo_we) pulse_seen++;
            tick();
        end
        checkOutput("multu_iter_flags", pulse_seen, 0);
        checkOutput("multu_hilo_sel", mul_sel, 6'h3F);
        checkOutput("multu_hilo_we", hilo_we, 1);
        checkOutput("multu_hilo_done", done, 1);
        checkOutput("multu_hilo_busy", busy, 1);
        tick();
        checkOutput("multu_after_sel", alu_sel, 6'd25);
        checkOutput("multu_after_busy", busy, 0);
        checkOutput("multu_after_done", done, 0);
        checkOutput("multu_after_we", hilo_we, 0);
        checkOutput("multu_after_iter", iter, 0);

        // DIVU with WIDTH=8, start held with ADD while busy
        start8 = 1'b1;
        funct8 = 6'd27;
        tick();
        funct8 = 6'd32;
        pulse_seen = 0;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("divu_iter_%0d", k), iter8, k);
            if (!busy8 || done8 || hilo_we8 || (alu_sel8 !== 6'd27)) pulse_seen++;
            tick();
        end
        checkOutput("divu_iter_flags", pulse_seen, 0);
        checkOutput("divu_hilo_sel", sht_sel8, 6'h3F);
        checkOutput("divu_hilo_we", hilo_we8, 1);
        checkOutput("divu_hilo_done", done8, 1);
        start8 = 1'b0;
        tick();
        checkOutput("divu_after_done", done8, 0);
        checkOutput("divu_after_busy", busy8, 0);
        checkOutput("divu_after_sel", alu_sel8, 6'd27);
        tick();
        checkOutput("divu_no_extra_done", done8, 0);

        // Unsupported funct leaves the selects alone
        applyStimulus(1'b1, 6'h3E);
        tick();
        applyStimulus(1'b0, 6'd0);
        checkOutput("illegal_pulse", illegal, 1);
        checkOutput("illegal_done", done, 0);
        checkOutput("illegal_sel", alu_sel, 6'd25);
        tick();
        checkOutput("illegal_clear", illegal, 0);
        checkOutput("illegal_sel_hold", mux_sel, 6'd25);

        // Reset in the middle of MULTU
        applyStimulus(1'b1, 6'd25);
        tick();
        applyStimulus(1'b0, 6'd0);
        for (int k = 0; k < 10; k++) tick();
        checkOutput("abort_iter_before", iter, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_iter", iter, 0);
        checkOutput("abort_sel", alu_sel, 6'h20);
        pulse_seen = 0;
        for (int k = 0; k < 30; k++) begin
            if (hilo_we || done || busy) pulse_seen++;
            tick();
        end
        checkOutput("abort_no_hilo", pulse_seen, 0);

        // Fresh MULTU after the abort
        applyStimulus(1'b1, 6'd25);
        tick();
        applyStimulus(1'b0, 6'd0);
        for (int k = 0; k < 32; k++) tick();
        checkOutput("fresh_hilo_we", hilo_we, 1);
        checkOutput("fresh_done", done, 1);
        checkOutput("fresh_sel", alu_sel, 6'h3F);
        tick();
        checkOutput("fresh_after_sel", alu_sel, 6'd25);
        checkOutput("fresh_after_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Parameterised successor to the ALU control decoder. It accepts a 6-bit MIPS funct code through a start/busy/done handshake and drives the select buses for the ALU, shifter, multiplier/divider and result mux. For the multi-cycle MULTU and DIVU ops it sequences exactly WIDTH iteration cycles, then issues a one-cycle HiLo write. It sits between instruction decode and the datapath units.

## Interface
- WIDTH, 32, operand width; the number of iteration cycles for MULTU/DIVU (legal range 2..64).
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- funct  in  6  funct code, sampled with start.
- alu_sel  out  6  select to ALU.
- sht_sel  out  6  select to shifter.
- mul_sel  out  6  select to multiplier/divider.
- mux_sel  out  6  select to result mux.
- busy  out  1  high while a multi-cycle op is in progress (ITER and HILO states).
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  one-cycle HiLo register write enable.
- illegal  out  1  one-cycle pulse when an unsupported funct is accepted.
- iter  out  CNT_W  current iteration index.

## Operation
- Supported funct codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, DIVU 27. HILO_OPEN is 6'b111111.
- All four select outputs always carry the same value, sel_q.
- States:
  - IDLE. If start and funct is single-cycle: sel_q <= funct, done pulses next cycle, state stays IDLE.
  - IDLE. If start and funct is MULTU/DIVU: sel_q <= funct, iter <= 0, go to ITER.
  - IDLE. If start and funct is unsupported: illegal pulses next cycle, sel_q is unchanged, no done, state stays IDLE.
  - ITER. iter increments each cycle. In the cycle where iter == WIDTH-1, go to HILO.
  - HILO. Lasts one cycle: sel_q = HILO_OPEN, hilo_we = 1, done = 1. Then return to IDLE with sel_q restored to the latched funct and iter <= 0.
- start outside IDLE is ignored. It is not queued, and funct changes are ignored.
- Reset values: sel_q = 6'b100000 (ADD), busy = 0, done = 0, hilo_we = 0, illegal = 0, iter = 0, state IDLE.
- Reset asserted in any state aborts the current op at the next edge. No hilo_we or done is issued for an aborted op.
- iter never exceeds WIDTH-1. The counter must not wrap within an op.

## Timing
- Single-cycle op accepted at edge N: sel_q = funct and done = 1 during cycle N+1. Back-to-back starts are accepted every cycle.
- Multi-cycle op accepted at edge N:
  - busy = 1 and iter = 0..WIDTH-1 during cycles N+1..N+WIDTH.
  - HILO occupies cycle N+WIDTH+1, with busy = 1, hilo_we = 1 and done = 1.
  - IDLE from N+WIDTH+2, where a new start is accepted.
- A start presented during the HILO cycle is ignored.
- done, hilo_we and illegal are registered outputs, each high for exactly one cycle per event.

## Structure
- Shared package alu_ctrl_pkg holds:
  - funct localparams (FN_AND … FN_DIVU) and HILO_OPEN;
  - the state enum (IDLE, ITER, HILO);
  - the is_multicycle() and is_supported() functions.
- One sub-module, iter_counter: a parameterised CNT_W counter with clear, enable and a terminal flag at WIDTH-1. It is reusable by the divider.

## Test plan
- Reset then idle: with rst held for 2 cycles, all outputs match the reset values and sel = 6'h20.
- Single-cycle ops: start with funct 36, 37, 32, 34, 42, 0 on consecutive cycles -> each select equals the funct one cycle later, with one done per op and busy never high.
- MULTU with WIDTH=32: start/funct=25 at edge N -> busy high cycles N+1..N+33, iter reaches 31 at N+32, sel = 6'h3F with hilo_we and done high only at N+33, sel = 25 at N+34.
- DIVU with WIDTH=8, plus start re-asserted with funct=32 while busy -> ignored; HILO occurs at N+9 and there is no extra done.
- Illegal funct 6'h3E -> illegal pulses once, sel unchanged, done stays 0.
- rst asserted at iter = 10 during MULTU -> state IDLE and iter = 0 next cycle; no hilo_we follows; a fresh MULTU then completes normally.
